line_loader: RTL and testbench

//  Writer side of the instruction line memory: assembles a byte stream into LINE_WIDTH-bit code lines.

---
 rtl/line_loader_pkg.sv | 25 ++
 rtl/line_loader_byte_packer.sv | 64 ++++++
 rtl/line_loader.sv | 123 ++++++++++++
 tb/tb_line_loader.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_loader_pkg.sv
// Shared definitions for the instruction line loader: default geometry,
// FSM state encoding and small sizing helpers.
package line_loader_pkg;

    localparam int DEF_LINE_WIDTH = 32;
    localparam int DEF_IP_WIDTH   = 8;

    // Loader FSM states (plain constants so older tools and dumps stay readable)
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    // Number of bytes that make up one code line
    function automatic int bytes_per_line(input int line_width);
        return line_width / 8;
    endfunction

    // Width of a counter that indexes nb bytes; never zero so a 1-byte line still elaborates
    function automatic int cnt_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/line_loader_byte_packer.sv
// Byte packer: shifts bytes in MSB-first into a LINE_WIDTH-bit line and
// flags the transfer that completes the line. The first byte of a line ends
// up in the top byte lane once all lanes have been filled.
module line_loader_byte_packer
    import line_loader_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [7:0]            byte_in,
    output logic [LINE_WIDTH-1:0] line,
    output logic                  line_full
);

    localparam int NB = bytes_per_line(LINE_WIDTH);
    localparam int CW = cnt_width(NB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

    logic [CW-1:0]       cnt_reg;
    logic [NB-1:0][7:0]  lane_reg;
    logic                cnt_at_last;

    assign cnt_at_last = (cnt_reg == CNT_LAST);
    assign line_full   = shift_en & cnt_at_last;
    assign line        = lane_reg;

    // Byte position within the current line; wraps to 0 after the last byte
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (shift_en) begin
            cnt_reg <= cnt_at_last ? '0 : cnt_reg + 1'b1;
        end
    end

    // Each lane takes the byte from the lane below; lane 0 takes the new byte
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge n_rst) begin
                    if (!n_rst) begin
                        lane_reg[gi] <= '0;
                    end else if (shift_en) begin
                        lane_reg[gi] <= byte_in;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge n_rst) begin
                    if (!n_rst) begin
                        lane_reg[gi] <= '0;
                    end else if (shift_en) begin
                        lane_reg[gi] <= lane_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/line_loader.sv
// Line loader: assembles a byte stream into code lines and writes them to
// consecutive line addresses from 0, holding the CPU halted while loading.
// An all-ones line is written and ends the load; running out of addresses
// before that ends it in an error state that keeps the CPU halted.
module line_loader
    import line_loader_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int IP_WIDTH   = DEF_IP_WIDTH
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [IP_WIDTH-1:0]   wr_addr,
    output logic [LINE_WIDTH-1:0] wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [IP_WIDTH:0]     line_count
);

    localparam logic [IP_WIDTH-1:0]   LAST_ADDR = '1;
    localparam logic [LINE_WIDTH-1:0] END_LINE  = '1;

    logic [2:0]            state_reg;
    logic [2:0]            state_next;
    logic [IP_WIDTH-1:0]   addr_reg;
    logic [IP_WIDTH:0]     count_reg;
    logic                  start_ok;
    logic                  shift_en;
    logic                  line_full;
    logic [LINE_WIDTH-1:0] line;

    // start only counts when no load is in flight
    assign start_ok = start & ((state_reg == ST_IDLE) ||
                               (state_reg == ST_DONE) ||
                               (state_reg == ST_ERR));
    assign shift_en = in_valid & in_ready;

    line_loader_byte_packer #(
        .LINE_WIDTH(LINE_WIDTH)
    ) u_packer (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (start_ok),
        .shift_en (shift_en),
        .byte_in  (in_data),
        .line     (line),
        .line_full(line_full)
    );

    // Next-state decision; WRITE always lasts exactly one cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (line_full) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (line == END_LINE) begin
                    state_next = ST_DONE;
                end else if (addr_reg == LAST_ADDR) begin
                    state_next = ST_ERR;
                end else begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Line address: restarts at 0 per load, advances only after a non-final write
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_reg <= '0;
        end else if (start_ok) begin
            addr_reg <= '0;
        end else if ((state_reg == ST_WRITE) && (state_next == ST_LOAD)) begin
            addr_reg <= addr_reg + 1'b1;
        end
    end

    // Lines written in this load, including the end line; one extra bit so a full memory fits
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_reg <= '0;
        end else if (start_ok) begin
            count_reg <= '0;
        end else if (state_reg == ST_WRITE) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Outputs decoded from state; address and data hold their last values after a load
    always_comb begin
        in_ready = (state_reg == ST_LOAD);
        wr_en    = (state_reg == ST_WRITE);
        cpu_hold = (state_reg == ST_LOAD) || (state_reg == ST_WRITE) || (state_reg == ST_ERR);
        done     = (state_reg == ST_DONE);
        err      = (state_reg == ST_ERR);
    end

    assign wr_addr    = addr_reg;
    assign wr_data    = line;
    assign line_count = count_reg;

endmodule

// File: tb/tb_line_loader.sv
// Testbench for line_loader: drives byte streams with random gaps, records
// every memory write with its latency from the last byte transfer, and
// compares against expected writes derived from the word list of each load.
`timescale 1ns/1ps
module tb_line_loader;

    localparam int LW = 32;
    localparam int IW = 8;
    localparam int DEPTH = 1 << IW;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [LW-1:0] wr_data;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [IW:0]   line_count;

    int n_cmp  = 0;
    int n_fail = 0;

    line_loader #(.LINE_WIDTH(LW), .IP_WIDTH(IW)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .line_count(line_count)
    );

    always #5 clk = ~clk;

    // ---------------- write monitor ----------------
    int            cyc = 0;
    int            last_xfer = 0;
    logic [IW-1:0] mon_addr[$];
    logic [LW-1:0] mon_data[$];
    int            mon_lat[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (n_rst) begin
            if (in_valid && in_ready) last_xfer = cyc;
            if (wr_en) begin
                mon_addr.push_back(wr_addr);
                mon_data.push_back(wr_data);
                mon_lat.push_back(cyc - last_xfer);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [LW-1:0] stim[$];
    logic [IW-1:0] exp_addr[$];
    logic [LW-1:0] exp_data[$];
    logic          exp_done;
    logic          exp_err;

    // Line i goes to address i; the end word or the last address ends the load
    task automatic build_expected();
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int i = 0; i < stim.size(); i++) begin
            exp_addr.push_back(i[IW-1:0]);
            exp_data.push_back(stim[i]);
            if (stim[i] == {LW{1'b1}}) begin
                exp_done = 1'b1;
                break;
            end
            if (i == DEPTH - 1) begin
                exp_err = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] w;
        w = $urandom;
        if (w == {LW{1'b1}}) w = '0;
        return w;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL send_byte_timeout: in_ready=%0b required 1 within 200 cycles", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic feed_stim(input int max_gap);
        for (int w = 0; w < stim.size(); w++) begin
            for (int k = 0; k < LW/8; k++) begin
                send_byte(stim[w][LW-1-8*k -: 8], $urandom_range(0, max_gap));
            end
        end
        tick();
        tick();
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        mon_lat.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({in_ready, wr_en, cpu_hold, done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000", {in_ready, wr_en, cpu_hold, done, err});
        end
        n_cmp++;
        if (wr_addr !== '0 || wr_data !== '0 || line_count !== '0) begin
            n_fail++;
            $display("FAIL reset_values: addr=%h data=%h count=%0d required 0/0/0", wr_addr, wr_data, line_count);
        end
        n_rst = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_outputs: in_ready=%b cpu_hold=%b required 0/0", in_ready, cpu_hold);
        end
        $display("test_reset done");
    endtask

    task automatic test_program();
        stim = '{32'h03000f00, 32'h03010600, 32'hffffffff};
        build_expected();
        clear_mon();
        pulse_start();
        n_cmp++;
        if (cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_outputs: cpu_hold=%b in_ready=%b required 1/1", cpu_hold, in_ready);
        end
        feed_stim(0);
        n_cmp++;
        if (mon_data.size() != exp_data.size()) begin
            n_fail++;
            $display("FAIL program_writes: got %0d writes required %0d", mon_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < mon_data.size(); i++) begin
            n_cmp++;
            if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i] || mon_lat[i] != 1) begin
                n_fail++;
                $display("FAIL program_w%0d: addr=%h data=%h lat=%0d required %h %h 1",
                         i, mon_addr[i], mon_data[i], mon_lat[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0 || in_ready !== 1'b0 || line_count !== 9'd3) begin
            n_fail++;
            $display("FAIL program_end: done=%b err=%b hold=%b rdy=%b count=%0d required 1 0 0 0 3",
                     done, err, cpu_hold, in_ready, line_count);
        end
        n_cmp++;
        if (wr_addr !== 8'd2 || wr_data !== 32'hffffffff || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hold: addr=%h data=%h wr_en=%b required 02 ffffffff 0", wr_addr, wr_data, wr_en);
        end
        $display("test_program done: %0d writes", mon_data.size());
    endtask

    task automatic test_byte_order();
        stim = '{32'h12345678, 32'hffffffff};
        build_expected();
        clear_mon();
        pulse_start();
        feed_stim(0);
        n_cmp++;
        if (mon_data.size() < 1 || mon_data[0] !== 32'h12345678 || mon_lat[0] != 1) begin
            n_fail++;
            $display("FAIL byte_order: writes=%0d data=%h lat=%0d required 12345678 lat 1",
                     mon_data.size(), (mon_data.size() > 0) ? mon_data[0] : 32'h0,
                     (mon_lat.size() > 0) ? mon_lat[0] : -1);
        end
        $display("test_byte_order done");
    endtask

    task automatic test_stall_random();
        for (int it = 0; it < 4; it++) begin
            int nl;
            nl = $urandom_range(1, 6);
            stim.delete();
            for (int i = 0; i < nl; i++) stim.push_back(rand_line());
            stim.push_back(32'hffffffff);
            build_expected();
            clear_mon();
            pulse_start();
            feed_stim(3);
            n_cmp++;
            if (mon_data.size() != exp_data.size()) begin
                n_fail++;
                $display("FAIL stall_writes_it%0d: got %0d required %0d", it, mon_data.size(), exp_data.size());
            end
            for (int i = 0; i < exp_data.size() && i < mon_data.size(); i++) begin
                n_cmp++;
                if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i] || mon_lat[i] != 1) begin
                    n_fail++;
                    $display("FAIL stall_it%0d_w%0d: addr=%h data=%h lat=%0d required %h %h 1",
                             it, i, mon_addr[i], mon_data[i], mon_lat[i], exp_addr[i], exp_data[i]);
                end
            end
            n_cmp++;
            if (done !== exp_done || line_count !== 9'(exp_data.size())) begin
                n_fail++;
                $display("FAIL stall_end_it%0d: done=%b count=%0d required %b %0d",
                         it, done, line_count, exp_done, exp_data.size());
            end
            $display("test_stall_random it%0d: %0d lines", it, nl + 1);
        end
    endtask

    task automatic test_overflow(input logic end_at_last);
        stim.delete();
        for (int i = 0; i < DEPTH - 1; i++) stim.push_back(rand_line());
        stim.push_back(end_at_last ? 32'hffffffff : rand_line());
        build_expected();
        clear_mon();
        pulse_start();
        feed_stim(0);
        n_cmp++;
        if (mon_data.size() != exp_data.size()) begin
            n_fail++;
            $display("FAIL full_writes_e%0b: got %0d required %0d", end_at_last, mon_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < mon_data.size(); i++) begin
            n_cmp++;
            if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL full_e%0b_w%0d: addr=%h data=%h required %h %h",
                         end_at_last, i, mon_addr[i], mon_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (done !== exp_done || err !== exp_err || cpu_hold !== exp_err || line_count !== 9'd256) begin
            n_fail++;
            $display("FAIL full_end_e%0b: done=%b err=%b hold=%b count=%0d required %b %b %b 256",
                     end_at_last, done, err, cpu_hold, line_count, exp_done, exp_err, exp_err);
        end
        // A byte offered after the load must not be taken
        in_valid = 1'b1;
        in_data  = 8'h5a;
        tick();
        n_cmp++;
        if (in_ready !== 1'b0 || mon_data.size() != exp_data.size()) begin
            n_fail++;
            $display("FAIL after_load_e%0b: in_ready=%b writes=%0d required 0 %0d",
                     end_at_last, in_ready, mon_data.size(), exp_data.size());
        end
        in_valid = 1'b0;
        $display("test_overflow end_at_last=%0b done", end_at_last);
    endtask

    task automatic test_reset_mid_load();
        logic [LW-1:0] w0;
        w0 = rand_line();
        clear_mon();
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(w0[LW-1-8*k -: 8], 0);
        send_byte(8'hab, 0);
        send_byte(8'hcd, 0);
        n_rst = 1'b0;
        #2;
        n_cmp++;
        if ({in_ready, wr_en, cpu_hold, done, err} !== 5'b0 || wr_addr !== '0 ||
            wr_data !== '0 || line_count !== '0) begin
            n_fail++;
            $display("FAIL async_reset: flags=%b addr=%h data=%h count=%0d required all 0",
                     {in_ready, wr_en, cpu_hold, done, err}, wr_addr, wr_data, line_count);
        end
        tick();
        n_rst = 1'b1;
        tick();
        stim = '{rand_line(), 32'hffffffff};
        build_expected();
        clear_mon();
        pulse_start();
        feed_stim(1);
        n_cmp++;
        if (mon_data.size() != 2 || mon_addr[0] !== 8'd0 || mon_data[0] !== exp_data[0] ||
            mon_addr[1] !== 8'd1 || done !== 1'b1 || line_count !== 9'd2) begin
            n_fail++;
            $display("FAIL restart_after_reset: writes=%0d done=%b count=%0d required 2 writes from addr 0, done 1, count 2",
                     mon_data.size(), done, line_count);
        end
        $display("test_reset_mid_load done");
    endtask

    task automatic test_start_ignored();
        clear_mon();
        // start together with a byte while DONE: byte must not be accepted this cycle
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h12;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_byte: in_ready=%b required 0", in_ready);
        end
        tick();
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || in_ready !== 1'b1 || line_count !== '0) begin
            n_fail++;
            $display("FAIL rearm: done=%b in_ready=%b count=%0d required 0 1 0", done, in_ready, line_count);
        end
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        pulse_start();
        send_byte(8'h56, 1);
        send_byte(8'h78, 0);
        for (int k = 0; k < 4; k++) send_byte(8'hff, 0);
        tick();
        n_cmp++;
        if (mon_data.size() != 2 || mon_data[0] !== 32'h12345678 || mon_addr[0] !== 8'd0 ||
            mon_addr[1] !== 8'd1 || done !== 1'b1 || line_count !== 9'd2) begin
            n_fail++;
            $display("FAIL start_ignored: writes=%0d data0=%h done=%b count=%0d required 2 12345678 1 2",
                     mon_data.size(), (mon_data.size() > 0) ? mon_data[0] : 32'h0, done, line_count);
        end
        $display("test_start_ignored done");
    endtask

    initial begin
        test_reset();
        test_program();
        test_byte_order();
        test_stall_random();
        test_overflow(1'b0);
        test_overflow(1'b1);
        test_reset_mid_load();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time exceeded, required completion");
        $fatal(1, "timeout");
    end

endmodule
